// File: rtl/sdmod.sv
// sdmod: sigma-delta modulator, 16-bit signed samples to a DSDOUT/SDCLK pair.
// Define SDMOD_ORDER2_EN for the saturating second-order loop; default is first-order.
module sdmod (
  input  logic        SYSCLK,
  input  logic        SYSRST,
  input  logic        en,
  input  logic [7:0]  div,
  input  logic [7:0]  osr,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        DSDOUT,
  output logic        SDCLK,
  output logic        underrun,
  output logic        overload
);

  logic [7:0]         cnt;
  logic [7:0]         ocnt;
  logic signed [15:0] x;
  logic signed [15:0] hold;
  logic               full;
  logic               tick;
  logic               step;
  logic               wrap;
  logic               xfer;
  logic               y;

  assign din_ready = ~full;
  assign xfer      = din_valid & ~full;
  // >= lets a lowered div or osr take effect without waiting for wrap
  assign tick      = en & (cnt >= div);
  assign step      = tick & SDCLK;
  assign wrap      = ocnt >= osr;

  always_ff @(posedge SYSCLK) begin
    if (SYSRST) begin
      cnt      <= '0;
      ocnt     <= '0;
      SDCLK    <= 1'b0;
      DSDOUT   <= 1'b0;
      underrun <= 1'b0;
      x        <= '0;
      hold     <= '0;
      full     <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (xfer) begin
        hold <= din;
        full <= 1'b1;
      end
      if (!en) begin
        cnt    <= '0;
        ocnt   <= '0;
        SDCLK  <= 1'b0;
        DSDOUT <= 1'b0;
        x      <= '0;
      end else begin
        if (tick) begin
          cnt   <= '0;
          SDCLK <= ~SDCLK;
        end else begin
          cnt <= cnt + 8'd1;
        end
        if (step) begin
          DSDOUT <= y;
          if (wrap) begin
            ocnt <= '0;
            if (full) begin
              x    <= hold;
              full <= 1'b0;
            end else begin
              underrun <= 1'b1;
            end
          end else begin
            ocnt <= ocnt + 8'd1;
          end
        end
      end
    end
  end

`ifdef SDMOD_ORDER2_EN

  localparam logic signed [25:0] SMAX = 26'sd8388607;
  localparam logic signed [25:0] SMIN = -26'sd8388607;

  logic signed [23:0] int1;
  logic signed [23:0] int2;
  logic signed [23:0] n1;
  logic signed [23:0] n2;
  logic signed [25:0] s1;
  logic signed [25:0] s2;
  logic signed [25:0] fb;
  logic               sat1;
  logic               sat2;

  assign y  = ~int2[23];
  assign fb = y ? 26'sd32768 : -26'sd32768;

  always_comb begin
    s1   = {{2{int1[23]}}, int1} + {{10{x[15]}}, x} - fb;
    n1   = s1[23:0];
    sat1 = 1'b0;
    if (s1 > SMAX) begin
      n1   = SMAX[23:0];
      sat1 = 1'b1;
    end else if (s1 < SMIN) begin
      n1   = SMIN[23:0];
      sat1 = 1'b1;
    end
    // second stage integrates the freshly updated first stage
    s2   = {{2{n1[23]}}, n1} + {{2{int2[23]}}, int2} - fb;
    n2   = s2[23:0];
    sat2 = 1'b0;
    if (s2 > SMAX) begin
      n2   = SMAX[23:0];
      sat2 = 1'b1;
    end else if (s2 < SMIN) begin
      n2   = SMIN[23:0];
      sat2 = 1'b1;
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (SYSRST || !en) begin
      int1     <= '0;
      int2     <= '0;
      overload <= 1'b0;
    end else begin
      overload <= step & (sat1 | sat2);
      if (step) begin
        int1 <= n1;
        int2 <= n2;
      end
    end
  end

`else

  logic signed [17:0] acc;
  logic signed [17:0] nacc;
  logic signed [17:0] fb;

  assign y        = ~acc[17];
  assign fb       = y ? 18'sd32768 : -18'sd32768;
  // acc stays within +/-2^16, so 18 bits never wrap
  assign nacc     = acc + {{2{x[15]}}, x} - fb;
  assign overload = 1'b0;

  always_ff @(posedge SYSCLK) begin
    if (SYSRST || !en) begin
      acc <= '0;
    end else if (step) begin
      acc <= nacc;
    end
  end

`endif

endmodule

// File: tb/tb_sdmod.sv
// tb_sdmod: random and directed stimulus for sdmod against a behavioural model.
// Model tracks SDCLK phase, step index and a one-deep sample queue in plain ints.
module tb_sdmod;

  logic        clk = 1'b0;
  logic        SYSRST;
  logic        en;
  logic [7:0]  div;
  logic [7:0]  osr;
  logic [15:0] din;
  logic        din_valid;
  logic        din_ready;
  logic        DSDOUT;
  logic        SDCLK;
  logic        underrun;
  logic        overload;

  sdmod dut (
    .SYSCLK    (clk),
    .SYSRST    (SYSRST),
    .en        (en),
    .div       (div),
    .osr       (osr),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .DSDOUT    (DSDOUT),
    .SDCLK     (SDCLK),
    .underrun  (underrun),
    .overload  (overload)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // behavioural model
  int m_sdclk = 0, m_dout = 0, m_phase = 0, m_idx = 0;
  int m_x = 0, m_acc = 0, m_i1 = 0, m_i2 = 0;
  int m_under = 0, m_over = 0;
  int hq[$];

  function automatic int sat24(int v);
    if (v > 8388607) return 8388607;
    if (v < -8388607) return -8388607;
    return v;
  endfunction

  task automatic model_clear();
    m_sdclk = 0; m_dout = 0; m_phase = 0; m_idx = 0;
    m_x = 0; m_acc = 0; m_i1 = 0; m_i2 = 0;
    m_under = 0; m_over = 0;
  endtask

  task automatic model_tick();
    int y, fb, a1, a2;
    bit was_full;
    if (SYSRST) begin
      model_clear();
      hq.delete();
      return;
    end
    m_under = 0;
    m_over = 0;
    was_full = (hq.size() != 0);
    if (!en) begin
      model_clear();
    end else if (m_phase >= int'(div)) begin
      m_phase = 0;
      if (m_sdclk == 1) begin
`ifdef SDMOD_ORDER2_EN
        y = (m_i2 >= 0) ? 1 : 0;
        fb = y ? 32768 : -32768;
        a1 = m_i1 + m_x - fb;
        m_i1 = sat24(a1);
        a2 = m_i2 + m_i1 - fb;
        m_i2 = sat24(a2);
        m_over = (a1 != m_i1 || a2 != m_i2) ? 1 : 0;
`else
        y = (m_acc >= 0) ? 1 : 0;
        fb = y ? 32768 : -32768;
        m_acc = m_acc + m_x - fb;
        a1 = 0;
        a2 = 0;
`endif
        m_dout = y;
        if (m_idx >= int'(osr)) begin
          m_idx = 0;
          if (was_full) m_x = hq.pop_front();
          else m_under = 1;
        end else begin
          m_idx++;
        end
      end
      m_sdclk = 1 - m_sdclk;
    end else begin
      m_phase++;
    end
    if (din_valid && !was_full) hq.push_back(int'($signed(din)));
  endtask

  always @(posedge clk) model_tick();

  // monitor
  bit   mon_on = 0;
  bit   cnt_on = 0;
  int   cyc = 0;
  int   n_steps = 0, n_ones = 0, n_under = 0, n_over = 0;
  int   bits_q[$];
  int   tog_q[$];
  logic p_sdclk = 1'b0;
  logic p_dout = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (mon_on) begin
      check("sdclk", int'(SDCLK), m_sdclk);
      check("dsdout", int'(DSDOUT), m_dout);
      check("din_ready", int'(din_ready), (hq.size() == 0) ? 1 : 0);
      check("underrun", int'(underrun), m_under);
      check("overload", int'(overload), m_over);
      if (DSDOUT != p_dout)
        check("dout_on_rise", int'(SDCLK && !p_sdclk), 0);
      if (SDCLK != p_sdclk) tog_q.push_back(cyc);
      if (cnt_on) begin
        if (p_sdclk && !SDCLK) begin
          n_steps++;
          n_ones += int'(DSDOUT);
          bits_q.push_back(int'(DSDOUT));
        end
        n_under += int'(underrun);
        n_over += int'(overload);
      end
    end
    p_sdclk = SDCLK;
    p_dout = DSDOUT;
  end

  task automatic cyc1();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_steps = 0; n_ones = 0; n_under = 0; n_over = 0;
    bits_q.delete();
  endtask

  task automatic wait_steps(int n, int budget);
    int k = 0;
    while (n_steps < n && k < budget) begin
      cyc1();
      k++;
    end
    if (n_steps < n) check("step_timeout", n_steps, n);
  endtask

  task automatic restart(int d, int o);
    cnt_on = 0;
    en = 1'b0;
    cyc1();
    div = 8'(d);
    osr = 8'(o);
    en = 1'b1;
  endtask

  int got;
  int k;
  int base;

  initial begin
    SYSRST = 1'b1;
    en = 1'b0;
    div = '0;
    osr = '0;
    din = '0;
    din_valid = 1'b0;
    cyc1();
    cyc1();
    mon_on = 1;
    check("rst_sdclk", int'(SDCLK), 0);
    check("rst_dsdout", int'(DSDOUT), 0);
    check("rst_ready", int'(din_ready), 1);
    check("rst_underrun", int'(underrun), 0);
    check("rst_overload", int'(overload), 0);

    // idle modulator: alternating bits, underrun every 4 steps
    SYSRST = 1'b0;
    div = 8'd0;
    osr = 8'd3;
    en = 1'b1;
    clear_counts();
    cnt_on = 1;
    wait_steps(16, 100);
    cnt_on = 0;
    if (bits_q.size() >= 4) begin
      check("idle_bit0", bits_q[0], 1);
      check("idle_bit1", bits_q[1], 0);
      check("idle_bit2", bits_q[2], 1);
      check("idle_bit3", bits_q[3], 0);
    end
    check("idle_underruns", n_under, 4);

    // full-scale negative input drives the stream to all zeros
    restart(0, 0);
    din = 16'h8000;
    din_valid = 1'b1;
    clear_counts();
    cnt_on = 1;
    wait_steps(16, 100);
    clear_counts();
    wait_steps(32, 200);
    cnt_on = 0;
    check("neg_full_ones", n_ones, 0);

    // three-quarter density
    restart(1, 15);
    din = 16'd16384;
    din_valid = 1'b1;
    clear_counts();
    cnt_on = 1;
    wait_steps(64, 400);
    clear_counts();
    wait_steps(256, 1400);
    cnt_on = 0;
`ifndef SDMOD_ORDER2_EN
    got = (n_ones >= 191 && n_ones <= 193) ? 192 : n_ones;
    check("ones_192", got, 192);
`endif
    check("dens_underrun", n_under, 0);
    din_valid = 1'b0;

    // div lowered from 3 to 1 while cnt is 2
    restart(3, 7);
    k = 0;
    while (m_phase != 2 && k < 20) begin
      cyc1();
      k++;
    end
    check("div_phase_found", m_phase, 2);
    div = 8'd1;
    tog_q.delete();
    base = cyc;
    repeat (8) cyc1();
    check("div_tog_count", int'(tog_q.size() >= 3), 1);
    if (tog_q.size() >= 3) begin
      check("div_first_tog", tog_q[0] - base, 1);
      check("div_half_per1", tog_q[1] - tog_q[0], 2);
      check("div_half_per2", tog_q[2] - tog_q[1], 2);
    end

    // near full-scale positive input
    restart(0, 0);
    din = 16'h7fff;
    din_valid = 1'b1;
    clear_counts();
    cnt_on = 1;
`ifdef SDMOD_ORDER2_EN
    wait_steps(4096, 9000);
    cnt_on = 0;
    check("ovl_seen", int'(n_over > 0), 1);
    check("ovl_density", int'(n_ones * 100 >= 99 * n_steps), 1);
`else
    wait_steps(1024, 2500);
    cnt_on = 0;
    check("ovl_none", n_over, 0);
`endif
    din_valid = 1'b0;

    // SYSRST mid-stream drops the held sample
    restart(0, 255);
    din = 16'd1234;
    din_valid = 1'b1;
    cyc1();
    din_valid = 1'b0;
    check("hold_full", int'(din_ready), 0);
    repeat (5) cyc1();
    SYSRST = 1'b1;
    cyc1();
    SYSRST = 1'b0;
    check("srst_sdclk", int'(SDCLK), 0);
    check("srst_dsdout", int'(DSDOUT), 0);
    check("srst_ready", int'(din_ready), 1);

    // en drop mid-stream keeps the held sample
    restart(0, 255);
    din = 16'd4321;
    din_valid = 1'b1;
    cyc1();
    din_valid = 1'b0;
    repeat (6) cyc1();
    en = 1'b0;
    cyc1();
    check("en0_sdclk", int'(SDCLK), 0);
    check("en0_dsdout", int'(DSDOUT), 0);
    check("en0_ready", int'(din_ready), 0);
    repeat (3) cyc1();
    check("en0_still_full", int'(din_ready), 0);

    // random traffic against the model
    for (int s = 0; s < 8; s++) begin
      div = 8'($urandom_range(0, 3));
      osr = 8'($urandom_range(0, 7));
      en = 1'b1;
      for (int c = 0; c < 400; c++) begin
        din_valid = 1'($urandom_range(0, 1));
        din = 16'($urandom);
        en = ($urandom_range(0, 99) != 0);
        SYSRST = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 49) == 0) div = 8'($urandom_range(0, 3));
        if ($urandom_range(0, 99) == 0) osr = 8'($urandom_range(0, 7));
        cyc1();
      end
    end
    SYSRST = 1'b0;
    cyc1();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
